// File: rtl/slot_pkg.sv
// Shared types and helpers for the reel spin controller: FSM states,
// random-to-symbol folding and the per-reel auto-stop point.
package slot_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SPIN = 1'b1
    } spin_state_t;

    // Fold an out-of-range random value back into the legal symbol range.
    function automatic int unsigned sym_map(input int unsigned m, input int unsigned num_syms);
        if (m >= num_syms) begin
            return m - num_syms;
        end else begin
            return m;
        end
    endfunction

    function automatic int unsigned stop_point(input int unsigned spin_ticks,
                                               input int unsigned num_reels,
                                               input int unsigned stagger,
                                               input int unsigned reel);
        return spin_ticks - (num_reels - 32'd1 - reel) * stagger;
    endfunction

endpackage

// File: rtl/reel_tick_gen.sv
// Free-running divider with one registered tick pulse per reel; reel i
// ticks on each rising edge of divider bit BASE_DIV_W-1+i.
module reel_tick_gen #(
    parameter int NUM_REELS  = 3,
    parameter int BASE_DIV_W = 20
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic [NUM_REELS-1:0] tick
);

    localparam int DIV_W = BASE_DIV_W + NUM_REELS;

    logic [DIV_W-1:0]     div_r;
    logic [NUM_REELS-1:0] bit_q_r;
    logic [NUM_REELS-1:0] tick_r;
    logic [NUM_REELS-1:0] bits_s;

    assign bits_s = div_r[BASE_DIV_W-1 +: NUM_REELS];

    // Divider count plus delayed tap bits for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_r   <= '0;
            bit_q_r <= '0;
            tick_r  <= '0;
        end else begin
            div_r   <= div_r + DIV_W'(1);
            bit_q_r <= bits_s;
            tick_r  <= bits_s & ~bit_q_r;
        end
    end

    assign tick = tick_r;

endmodule

// File: rtl/reel_spin_controller.sv
// N-reel slot sequencer: start edge detect, per-reel spinning, staggered
// auto-stop, player early stop, final match flags and a completion pulse.
module reel_spin_controller
    import slot_pkg::*;
#(
    parameter int NUM_REELS      = 3,
    parameter int SYM_W          = 3,
    parameter int NUM_SYMS       = 8,
    parameter int BASE_DIV_W     = 20,
    parameter int SPIN_TICKS     = 20,
    parameter int STOP_STAGGER   = 1,
    parameter int MIN_SPIN_TICKS = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [NUM_REELS-1:0]       stop_req,
    input  logic [NUM_REELS*SYM_W-1:0] rnd,
    output logic [NUM_REELS*SYM_W-1:0] sym_idx,
    output logic [NUM_REELS-1:0]       reel_stopped,
    output logic                       busy,
    output logic                       done,
    output logic                       all_match,
    output logic                       pair_match
);

    localparam int CNT_W = $clog2(SPIN_TICKS + 1);

    logic [NUM_REELS-1:0] tick_s;

    reel_tick_gen #(
        .NUM_REELS  (NUM_REELS),
        .BASE_DIV_W (BASE_DIV_W)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .tick (tick_s)
    );

    spin_state_t          state_r, state_s;
    logic                 start_q_r;
    logic [CNT_W-1:0]     cnt_r, cnt_s;
    logic [NUM_REELS-1:0] stopped_r, stopped_s;
    logic [SYM_W-1:0]     sym_r [NUM_REELS];
    logic [SYM_W-1:0]     sym_s [NUM_REELS];
    logic [SYM_W-1:0]     mapped_s [NUM_REELS];
    logic                 busy_r, busy_s, done_r, done_s;
    logic                 all_match_r, all_match_s, pair_match_r, pair_match_s;
    logic                 all_eq_s, pair_eq_s, start_edge_s;
    logic [NUM_REELS-1:0] auto_stop_s, early_stop_s;

    assign start_edge_s = start & ~start_q_r;

    // Per-reel stop conditions and the mapped random symbol.
    always_comb begin
        for (int i = 0; i < NUM_REELS; i++) begin
            mapped_s[i]     = SYM_W'(sym_map(32'(rnd[i*SYM_W +: SYM_W]), NUM_SYMS));
            auto_stop_s[i]  = tick_s[0] &&
                              ((32'(cnt_r) + 32'd1) == stop_point(SPIN_TICKS, NUM_REELS, STOP_STAGGER, i));
            early_stop_s[i] = stop_req[i] && (32'(cnt_r) >= 32'(MIN_SPIN_TICKS));
        end
    end

    // Match detection over the currently held symbols.
    always_comb begin
        all_eq_s  = 1'b1;
        pair_eq_s = 1'b0;
        for (int i = 1; i < NUM_REELS; i++) begin
            all_eq_s = all_eq_s & (sym_r[i] == sym_r[0]);
        end
        for (int i = 0; i < NUM_REELS - 1; i++) begin
            pair_eq_s = pair_eq_s | (sym_r[i] == sym_r[i+1]);
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_s      = state_r;
        cnt_s        = cnt_r;
        stopped_s    = stopped_r;
        sym_s        = sym_r;
        busy_s       = busy_r;
        done_s       = 1'b0;
        all_match_s  = all_match_r;
        pair_match_s = pair_match_r;
        case (state_r)
            IDLE: begin
                if (start_edge_s) begin
                    state_s      = SPIN;
                    busy_s       = 1'b1;
                    cnt_s        = '0;
                    stopped_s    = '0;
                    all_match_s  = 1'b0;
                    pair_match_s = 1'b0;
                end else begin
                    state_s = IDLE;
                end
            end
            SPIN: begin
                if (&stopped_r) begin
                    state_s      = IDLE;
                    busy_s       = 1'b0;
                    done_s       = 1'b1;
                    all_match_s  = all_eq_s;
                    pair_match_s = pair_eq_s;
                end else begin
                    if (tick_s[0] && (cnt_r < CNT_W'(SPIN_TICKS))) begin
                        cnt_s = cnt_r + CNT_W'(1);
                    end else begin
                        cnt_s = cnt_r;
                    end
                    // Tick, auto-stop and early stop all load the same value,
                    // so coincident events collapse into a single update.
                    for (int i = 0; i < NUM_REELS; i++) begin
                        if (!stopped_r[i] && (tick_s[i] || auto_stop_s[i] || early_stop_s[i])) begin
                            sym_s[i] = mapped_s[i];
                        end else begin
                            sym_s[i] = sym_r[i];
                        end
                        if (!stopped_r[i] && (auto_stop_s[i] || early_stop_s[i])) begin
                            stopped_s[i] = 1'b1;
                        end else begin
                            stopped_s[i] = stopped_r[i];
                        end
                    end
                end
            end
            default: begin
                state_s = IDLE;
                busy_s  = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= IDLE;
            start_q_r    <= 1'b0;
            cnt_r        <= '0;
            stopped_r    <= '1;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            all_match_r  <= 1'b0;
            pair_match_r <= 1'b0;
            for (int i = 0; i < NUM_REELS; i++) begin
                sym_r[i] <= SYM_W'(i % NUM_SYMS);
            end
        end else begin
            state_r      <= state_s;
            start_q_r    <= start;
            cnt_r        <= cnt_s;
            stopped_r    <= stopped_s;
            busy_r       <= busy_s;
            done_r       <= done_s;
            all_match_r  <= all_match_s;
            pair_match_r <= pair_match_s;
            sym_r        <= sym_s;
        end
    end

    for (genvar gi = 0; gi < NUM_REELS; gi++) begin : g_sym_out
        assign sym_idx[gi*SYM_W +: SYM_W] = sym_r[gi];
    end

    assign reel_stopped = stopped_r;
    assign busy         = busy_r;
    assign done         = done_r;
    assign all_match    = all_match_r;
    assign pair_match   = pair_match_r;

endmodule

// File: tb/tb_reel_spin_controller.sv
// Self-checking bench for reel_spin_controller: directed scenarios plus
// randomized spins against a cycle-level behavioural model.
module tb_reel_spin_controller;

    localparam int NR  = 3;
    localparam int SW  = 3;
    localparam int NS  = 6;
    localparam int BDW = 2;
    localparam int ST  = 5;
    localparam int SS  = 1;
    localparam int MST = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [NR-1:0]     stop_req;
    logic [NR*SW-1:0]  rnd;
    logic [NR*SW-1:0]  sym_idx;
    logic [NR-1:0]     reel_stopped;
    logic              busy, done, all_match, pair_match;

    always #5 clk = ~clk;

    reel_spin_controller #(
        .NUM_REELS(NR), .SYM_W(SW), .NUM_SYMS(NS), .BASE_DIV_W(BDW),
        .SPIN_TICKS(ST), .STOP_STAGGER(SS), .MIN_SPIN_TICKS(MST)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .stop_req(stop_req), .rnd(rnd),
        .sym_idx(sym_idx), .reel_stopped(reel_stopped), .busy(busy), .done(done),
        .all_match(all_match), .pair_match(pair_match)
    );

    int n_pass = 0;
    int n_total = 0;

    // reference model state
    bit m_spin, m_startq, m_busy, m_done, m_am, m_pm;
    int m_cnt, m_edge;
    int m_sym[NR];
    bit m_stopped[NR];

    int cyc = 0;
    int done_cnt, done_cyc;
    int stop_edge[NR];
    logic [NR-1:0] prev_stopped;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_total++;
        assert (obs === exp_v) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    endtask

    function automatic int map_sym(input int m);
        return (m >= NS) ? m - NS : m;
    endfunction

    // Reel i's tick is seen by the controller at edge e (counted from reset
    // release) when e-2 lands mid-period of its 2^(BDW+i) cycle divider tap.
    function automatic bit tick_at(input int i, input int e);
        int p;
        p = 1 << (BDW + i);
        return (e >= 2) && (((e - 2) % p) == (p / 2));
    endfunction

    task automatic model_reset();
        m_spin = 1'b0; m_startq = 1'b0; m_busy = 1'b0; m_done = 1'b0;
        m_am = 1'b0; m_pm = 1'b0; m_cnt = 0; m_edge = 0;
        for (int i = 0; i < NR; i++) begin
            m_sym[i] = i % NS;
            m_stopped[i] = 1'b1;
        end
    endtask

    task automatic model_edge();
        int n_sym[NR];
        bit n_stop[NR];
        int n_cnt, sp;
        bit all_stop, master, autos, early, nd;
        m_edge++;
        n_sym = m_sym; n_stop = m_stopped; n_cnt = m_cnt; nd = 1'b0;
        if (!m_spin) begin
            if (start && !m_startq) begin
                m_spin = 1'b1; m_busy = 1'b1; n_cnt = 0; m_am = 1'b0; m_pm = 1'b0;
                for (int i = 0; i < NR; i++) n_stop[i] = 1'b0;
            end
        end else begin
            all_stop = 1'b1;
            for (int i = 0; i < NR; i++) all_stop &= m_stopped[i];
            if (all_stop) begin
                m_spin = 1'b0; m_busy = 1'b0; nd = 1'b1;
                m_am = (m_sym[0] == m_sym[1]) && (m_sym[1] == m_sym[2]);
                m_pm = (m_sym[0] == m_sym[1]) || (m_sym[1] == m_sym[2]);
            end else begin
                master = tick_at(0, m_edge);
                for (int i = 0; i < NR; i++) begin
                    sp = ST - (NR - 1 - i) * SS;
                    autos = master && (m_cnt + 1 == sp);
                    early = stop_req[i] && (m_cnt >= MST);
                    if (!m_stopped[i] && (tick_at(i, m_edge) || autos || early)) begin
                        n_sym[i] = map_sym(int'(rnd[i*SW +: SW]));
                        if (autos || early) n_stop[i] = 1'b1;
                    end
                end
                if (master && m_cnt < ST) n_cnt = m_cnt + 1;
            end
        end
        m_done = nd; m_sym = n_sym; m_stopped = n_stop; m_cnt = n_cnt; m_startq = start;
    endtask

    function automatic logic [NR*SW-1:0] m_sym_vec();
        logic [NR*SW-1:0] v;
        for (int i = 0; i < NR; i++) v[i*SW +: SW] = SW'(m_sym[i]);
        return v;
    endfunction

    function automatic logic [NR-1:0] m_stop_vec();
        logic [NR-1:0] v;
        for (int i = 0; i < NR; i++) v[i] = m_stopped[i];
        return v;
    endfunction

    task automatic compare_all();
        chk("sym_idx", 32'(sym_idx), 32'(m_sym_vec()));
        chk("reel_stopped", 32'(reel_stopped), 32'(m_stop_vec()));
        chk("busy", 32'(busy), 32'(m_busy));
        chk("done", 32'(done), 32'(m_done));
        chk("all_match", 32'(all_match), 32'(m_am));
        chk("pair_match", 32'(pair_match), 32'(m_pm));
        for (int i = 0; i < NR; i++)
            chk("sym_range", 32'(sym_idx[i*SW +: SW] < SW'(NS)), 32'd1);
    endtask

    task automatic cycle();
        @(posedge clk);
        if (rst) model_reset();
        else model_edge();
        @(negedge clk);
        cyc++;
        compare_all();
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        for (int i = 0; i < NR; i++)
            if (!prev_stopped[i] && reel_stopped[i]) stop_edge[i] = cyc;
        prev_stopped = reel_stopped;
    endtask

    task automatic start_pulse();
        start = 1'b0;
        cycle();
        done_cnt = 0;
        done_cyc = -1;
        for (int i = 0; i < NR; i++) stop_edge[i] = -1;
        start = 1'b1;
        cycle();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input bit rand_mode);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < budget; k++) begin
            if (rand_mode) begin
                rnd = NR*SW'($urandom);
                stop_req = ($urandom_range(0, 5) == 0) ? NR'($urandom) : '0;
                start = 1'($urandom);
            end
            cycle();
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        if (rand_mode) begin
            stop_req = '0;
            start = 1'b0;
        end
        chk("done_timeout", 32'(seen), 32'd1);
    endtask

    initial begin
        bit seen;
        rst = 1'b1; start = 1'b0; stop_req = '0; rnd = '0;
        prev_stopped = '1;
        model_reset();
        #1;
        chk("por_sym_idx", 32'(sym_idx), 32'h088);
        chk("por_stopped", 32'(reel_stopped), 32'h7);
        cycle();
        cycle();
        rst = 1'b0;

        // full spin, every slice 6 -> symbol 0 everywhere
        rnd = {3'd6, 3'd6, 3'd6};
        start_pulse();
        wait_done(100, 1'b0);
        chk("t2_final_sym", 32'(sym_idx), 32'h000);
        chk("t2_all_match", 32'(all_match), 32'd1);
        chk("t2_pair_match", 32'(pair_match), 32'd1);
        chk("t2_order01", 32'(stop_edge[0] < stop_edge[1]), 32'd1);
        chk("t2_order12", 32'(stop_edge[1] < stop_edge[2]), 32'd1);
        cycle();
        cycle();
        chk("t2_one_done", 32'(done_cnt), 32'd1);

        // out-of-range slices fold down
        rnd = {3'd7, 3'd1, 3'd4};
        start_pulse();
        wait_done(100, 1'b0);
        chk("t3_final_sym", 32'(sym_idx), 32'h04C);
        chk("t3_all_match", 32'(all_match), 32'd0);
        chk("t3_pair_match", 32'(pair_match), 32'd1);

        // held early stop on reel 2
        stop_req = 3'b100;
        rnd = {3'd5, 3'd3, 3'd2};
        start_pulse();
        wait_done(100, 1'b0);
        stop_req = '0;
        chk("t4_reel2_first", 32'(stop_edge[2] < stop_edge[0]), 32'd1);
        chk("t4_auto_order", 32'(stop_edge[0] < stop_edge[1]), 32'd1);
        chk("t4_done_latency", 32'(done_cyc), 32'(stop_edge[1] + 1));

        // restart while busy, and start edge in the done cycle
        rnd = {3'd2, 3'd2, 3'd2};
        start_pulse();
        cycle();
        cycle();
        start = 1'b1;
        cycle();
        start = 1'b0;
        chk("t5_busy_restart_busy", 32'(busy), 32'd1);
        chk("t5_busy_restart_stopped", 32'(reel_stopped), 32'd0);
        seen = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (&reel_stopped) begin
                seen = 1'b1;
                break;
            end
            cycle();
        end
        chk("t5_all_stopped_seen", 32'(seen), 32'd1);
        chk("t5_pre_done", 32'(done), 32'd0);
        start = 1'b1;
        cycle();
        chk("t5_done_pulse", 32'(done), 32'd1);
        cycle();
        chk("t5_start_in_done_ignored", 32'(busy), 32'd0);
        chk("t5_match_held", 32'(all_match), 32'd1);
        start_pulse();
        wait_done(100, 1'b0);
        chk("t5_match_before_restart", 32'(all_match), 32'd1);
        start = 1'b1;
        cycle();
        start = 1'b0;
        chk("t5_start_after_done", 32'(busy), 32'd1);
        chk("t5_all_cleared", 32'(all_match), 32'd0);
        chk("t5_pair_cleared", 32'(pair_match), 32'd0);
        wait_done(100, 1'b0);

        // all reels stopped together at the minimum count
        stop_req = 3'b111;
        rnd = {3'd0, 3'd3, 3'd6};
        start_pulse();
        wait_done(100, 1'b0);
        stop_req = '0;
        chk("t6_same_edge01", 32'(stop_edge[0]), 32'(stop_edge[1]));
        chk("t6_same_edge12", 32'(stop_edge[1]), 32'(stop_edge[2]));
        chk("t6_done_next", 32'(done_cyc), 32'(stop_edge[0] + 1));
        chk("t6_busy_low", 32'(busy), 32'd0);

        // randomized spins
        for (int s = 0; s < 6; s++) begin
            rnd = NR*SW'($urandom);
            start_pulse();
            wait_done(200, 1'b1);
        end

        // asynchronous reset in the middle of a spin
        rnd = {3'd1, 3'd2, 3'd3};
        start_pulse();
        for (int k = 0; k < 10; k++) cycle();
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        chk("rst_sym_idx", 32'(sym_idx), 32'h088);
        chk("rst_stopped", 32'(reel_stopped), 32'h7);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_all_match", 32'(all_match), 32'd0);
        chk("rst_pair_match", 32'(pair_match), 32'd0);
        compare_all();
        cycle();
        rst = 1'b0;
        prev_stopped = reel_stopped;

        rnd = {3'd4, 3'd4, 3'd4};
        start_pulse();
        wait_done(100, 1'b0);
        chk("post_rst_all_match", 32'(all_match), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
